// File: rtl/sender_pkg.sv
// ---------------------------------------------------------------------------
// sender_pkg
// Shared types and constants for the HDMI sender frame sequencer.
//   seq_state_t  : sequencer states (IDLE, ARMED, FETCH, DRAIN)
//   FRAME_CNT_W  : width of the completed-frame counter
//   CREDIT_W     : width of the outstanding-line counter (MAX_OUT <= 7)
// ---------------------------------------------------------------------------
package sender_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        FETCH = 2'd2,
        DRAIN = 2'd3
    } seq_state_t;

    localparam int FRAME_CNT_W = 16;
    localparam int CREDIT_W    = 3;

endpackage

// File: rtl/sender_credit_cnt.sv
// ---------------------------------------------------------------------------
// sender_credit_cnt
// Counts lines requested from the fetcher but not yet reported done.
// Ports:
//   ACLK, ARESETN : clock, asynchronous active-low reset
//   inc           : a line request was accepted this cycle
//   dec           : a line finished this cycle (ignored while count is 0)
//   count         : registered outstanding count
//   below_max     : the count after this cycle's update is below MAX_OUT
//                   (combinational, lets the sequencer issue in the same edge)
// ---------------------------------------------------------------------------
module sender_credit_cnt
    import sender_pkg::*;
#(
    parameter int MAX_OUT = 2
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    input  logic                inc,
    input  logic                dec,
    output logic [CREDIT_W-1:0] count,
    output logic                below_max
);

    logic                w_dec_ok;
    logic [CREDIT_W-1:0] w_count_next;

    always_comb begin
        // A done pulse with nothing outstanding is spurious; drop it so the
        // count cannot wrap below zero.
        w_dec_ok     = dec && (count != '0);
        w_count_next = count;
        if (inc && !w_dec_ok) begin
            w_count_next = count + CREDIT_W'(1);
        end else if (!inc && w_dec_ok) begin
            w_count_next = count - CREDIT_W'(1);
        end
    end

    assign below_max = (w_count_next < CREDIT_W'(MAX_OUT));

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            count <= '0;
        end else begin
            count <= w_count_next;
        end
    end

endmodule

// File: rtl/sender_frame_seq.sv
// ---------------------------------------------------------------------------
// sender_frame_seq
// Sequences one HDMI sender frame at a time: on FRAME_START it requests lines
// 0..LINES-1 from the pixel line fetcher, never holding more than MAX_OUT
// lines outstanding, and flags an underrun when a new frame starts before the
// previous one has been fully fetched.
//
// Optional feature (macro SENDER_FRAME_CNT_EN): adds the FRAME_CNT output, a
// wrapping count of frames that drained without underrun.
//
// Ports:
//   ACLK, ARESETN  : clock, asynchronous active-low reset
//   SENDER_GO      : run enable level from the control registers
//   SENDER_RUN     : high whenever the sequencer is not IDLE
//   FRAME_START    : 1-cycle pulse at the start of vertical blanking
//   REQ_VALID/REQ_READY/REQ_LINE : line request handshake to the fetcher
//   LINE_DONE      : 1-cycle pulse, one requested line fully fetched
//   UNDERRUN       : sticky underrun flag; UNDERRUN_CLR clears it
//   DBG_STATE      : current sequencer state (seq_state_t encoding)
//   FRAME_CNT      : completed-frame count (SENDER_FRAME_CNT_EN only)
//
// Request handshake: a request transfers on a cycle where REQ_VALID and
// REQ_READY are both high. Once REQ_VALID is raised it stays high and
// REQ_LINE stays constant until that transfer, even if the frame is aborted.
// All outputs are registered.
// ---------------------------------------------------------------------------
module sender_frame_seq
    import sender_pkg::*;
#(
    parameter int LINES   = 480,
    parameter int LINE_W  = 10,
    parameter int MAX_OUT = 2
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              SENDER_GO,
    output logic              SENDER_RUN,
    input  logic              FRAME_START,
    output logic              REQ_VALID,
    input  logic              REQ_READY,
    output logic [LINE_W-1:0] REQ_LINE,
    input  logic              LINE_DONE,
    output logic              UNDERRUN,
    input  logic              UNDERRUN_CLR,
    output logic [1:0]        DBG_STATE
`ifdef SENDER_FRAME_CNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] FRAME_CNT
`endif
);

    // Line index needs one extra bit so that LINES itself is representable.
    localparam int               NL_W    = LINE_W + 1;
    localparam logic [NL_W-1:0]  LINES_C = NL_W'(LINES);

    seq_state_t          r_state;
    seq_state_t          w_state_next;
    logic [NL_W-1:0]     r_next_line;
    logic [NL_W-1:0]     w_next_line_next;
    logic [NL_W-1:0]     w_line_after;
    logic                w_req_valid_next;
    logic [LINE_W-1:0]   w_req_line_next;
    logic                w_underrun_next;
    logic                w_accept;
    logic                w_below_max;
    logic [CREDIT_W-1:0] w_outstanding;
    logic                w_frame_go;
    logic                w_drain_exit;
    logic                w_urun_set;

    assign w_accept     = REQ_VALID && REQ_READY;
    assign w_line_after = r_next_line + NL_W'(1);
    assign w_frame_go   = (r_state == ARMED) && SENDER_GO && FRAME_START;
    assign w_drain_exit = (r_state == DRAIN) && (w_outstanding == '0) && !REQ_VALID;
    assign w_urun_set   = FRAME_START && ((r_state == FETCH) || (r_state == DRAIN));
    assign DBG_STATE    = r_state;

    sender_credit_cnt #(
        .MAX_OUT (MAX_OUT)
    ) u_credit (
        .ACLK      (ACLK),
        .ARESETN   (ARESETN),
        .inc       (w_accept),
        .dec       (LINE_DONE),
        .count     (w_outstanding),
        .below_max (w_below_max)
    );

    always_comb begin
        w_state_next     = r_state;
        w_req_valid_next = REQ_VALID;
        w_req_line_next  = REQ_LINE;
        w_next_line_next = r_next_line;
        w_underrun_next  = UNDERRUN;

        case (r_state)
            IDLE: begin
                if (SENDER_GO) begin
                    w_state_next = ARMED;
                end
            end
            ARMED: begin
                if (!SENDER_GO) begin
                    w_state_next = IDLE;
                end else if (FRAME_START) begin
                    w_state_next     = FETCH;
                    w_req_valid_next = 1'b1;
                    w_req_line_next  = '0;
                    w_next_line_next = '0;
                end
            end
            FETCH: begin
                if (w_accept) begin
                    w_next_line_next = w_line_after;
                end
                if (FRAME_START) begin
                    // Abort: stop issuing, but a pending request must still
                    // complete its handshake.
                    w_state_next     = DRAIN;
                    w_req_valid_next = REQ_VALID && !w_accept;
                end else if (w_accept && (w_line_after == LINES_C)) begin
                    w_state_next     = DRAIN;
                    w_req_valid_next = 1'b0;
                end else if (REQ_VALID && !w_accept) begin
                    w_req_valid_next = 1'b1;
                end else if (w_below_max) begin
                    w_req_valid_next = 1'b1;
                    w_req_line_next  = w_next_line_next[LINE_W-1:0];
                end else begin
                    w_req_valid_next = 1'b0;
                end
            end
            DRAIN: begin
                if (w_accept) begin
                    w_req_valid_next = 1'b0;
                end
                if (w_drain_exit) begin
                    w_state_next = SENDER_GO ? ARMED : IDLE;
                end
            end
            default: begin
                w_state_next     = IDLE;
                w_req_valid_next = 1'b0;
            end
        endcase

        // Setting wins over a simultaneous clear.
        if (w_urun_set) begin
            w_underrun_next = 1'b1;
        end else if (UNDERRUN_CLR) begin
            w_underrun_next = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_state     <= IDLE;
            r_next_line <= '0;
            REQ_VALID   <= 1'b0;
            REQ_LINE    <= '0;
            UNDERRUN    <= 1'b0;
            SENDER_RUN  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_next_line <= w_next_line_next;
            REQ_VALID   <= w_req_valid_next;
            REQ_LINE    <= w_req_line_next;
            UNDERRUN    <= w_underrun_next;
            SENDER_RUN  <= (w_state_next != IDLE);
        end
    end

`ifdef SENDER_FRAME_CNT_EN
    logic                   r_frame_bad;
    logic [FRAME_CNT_W-1:0] r_frame_cnt;

    // r_frame_bad marks a frame that saw an underrun; an underrun on the
    // exit cycle itself also disqualifies the frame.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            r_frame_bad <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_frame_go) begin
                r_frame_bad <= 1'b0;
            end else if (w_urun_set) begin
                r_frame_bad <= 1'b1;
            end
            if (w_drain_exit && !r_frame_bad && !FRAME_START) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
        end
    end

    assign FRAME_CNT = r_frame_cnt;
`endif

endmodule

// File: tb/tb_sender_frame_seq.sv
// ---------------------------------------------------------------------------
// tb_sender_frame_seq
// Directed scenarios followed by randomized traffic, all compared cycle by
// cycle against a frame-level reference model. Inputs change on the falling
// edge; outputs are sampled on the falling edge. The fetcher is emulated by a
// queue of completion timers, one per accepted request, completing in order.
// ---------------------------------------------------------------------------
module tb_sender_frame_seq;
    import sender_pkg::*;

    localparam int LINES    = 4;
    localparam int LINE_W   = 10;
    localparam int MAX_OUT  = 2;
    localparam int DONE_LAT = 3;

    logic              ACLK         = 1'b0;
    logic              ARESETN      = 1'b0;
    logic              SENDER_GO    = 1'b0;
    logic              FRAME_START  = 1'b0;
    logic              REQ_READY    = 1'b0;
    logic              LINE_DONE    = 1'b0;
    logic              UNDERRUN_CLR = 1'b0;
    logic              SENDER_RUN;
    logic              REQ_VALID;
    logic              UNDERRUN;
    logic [LINE_W-1:0] REQ_LINE;
    logic [1:0]        DBG_STATE;
`ifdef SENDER_FRAME_CNT_EN
    logic [15:0]       FRAME_CNT;
`endif

    always #5 ACLK = ~ACLK;

    sender_frame_seq #(
        .LINES   (LINES),
        .LINE_W  (LINE_W),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .ACLK         (ACLK),
        .ARESETN      (ARESETN),
        .SENDER_GO    (SENDER_GO),
        .SENDER_RUN   (SENDER_RUN),
        .FRAME_START  (FRAME_START),
        .REQ_VALID    (REQ_VALID),
        .REQ_READY    (REQ_READY),
        .REQ_LINE     (REQ_LINE),
        .LINE_DONE    (LINE_DONE),
        .UNDERRUN     (UNDERRUN),
        .UNDERRUN_CLR (UNDERRUN_CLR),
        .DBG_STATE    (DBG_STATE)
`ifdef SENDER_FRAME_CNT_EN
        ,
        .FRAME_CNT    (FRAME_CNT)
`endif
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: frame-level view of the sequencer.
    seq_state_t m_phase;
    bit         m_valid;
    int         m_line;
    int         m_sent;   // lines of the current frame already handed over
    int         m_out;    // lines handed over but not yet done
    bit         m_urun;
    bit         m_bad;    // current frame hit an underrun
    int         m_fcnt;

    // Fetcher emulation and request log.
    int done_t[$];
    int acc_off[$];
    int acc_lines[$];
    bit hold_done  = 1'b0;
    bit done_pulse = 1'b0;
    int rand_lat   = 0;
    int c0         = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = IDLE;
        m_valid = 1'b0;
        m_line  = 0;
        m_sent  = 0;
        m_out   = 0;
        m_urun  = 1'b0;
        m_bad   = 1'b0;
        m_fcnt  = 0;
        done_t.delete();
    endtask

    task automatic compare_outputs();
        check("run", SENDER_RUN, m_phase != IDLE);
        check("state", DBG_STATE, m_phase);
        check("req_valid", REQ_VALID, m_valid);
        if (m_valid) check("req_line", REQ_LINE, m_line);
        check("underrun", UNDERRUN, m_urun);
`ifdef SENDER_FRAME_CNT_EN
        check("frame_cnt", FRAME_CNT, m_fcnt & 32'hFFFF);
`endif
    endtask

    // One clock: compare, drive LINE_DONE, advance the model, cross the edge.
    task automatic step();
        bit fire;
        bit acc;
        bit dn;
        bit urun_set;
        int out_n;
        int sent_n;
        compare_outputs();

        fire = 1'b0;
        foreach (done_t[i]) if (done_t[i] > 0) done_t[i]--;
        if (!hold_done && done_t.size() > 0 && done_t[0] == 0) begin
            fire = 1'b1;
            void'(done_t.pop_front());
        end
        LINE_DONE = fire | done_pulse;

        if (REQ_VALID && REQ_READY) begin
            done_t.push_back(rand_lat > 0 ? int'($urandom_range(1, rand_lat)) : DONE_LAT);
            acc_off.push_back(cyc - c0);
            acc_lines.push_back(int'(REQ_LINE));
            if (m_phase == FETCH) check("order", REQ_LINE, m_sent);
        end

        acc      = m_valid && REQ_READY;
        dn       = LINE_DONE && (m_out > 0);
        out_n    = m_out + int'(acc) - int'(dn);
        sent_n   = m_sent + int'(acc);
        urun_set = FRAME_START && (m_phase == FETCH || m_phase == DRAIN);

        case (m_phase)
            IDLE: if (SENDER_GO) m_phase = ARMED;
            ARMED: begin
                if (!SENDER_GO) m_phase = IDLE;
                else if (FRAME_START) begin
                    m_phase = FETCH;
                    m_valid = 1'b1;
                    m_line  = 0;
                    sent_n  = 0;
                    m_bad   = 1'b0;
                end
            end
            FETCH: begin
                if (FRAME_START) begin
                    m_bad   = 1'b1;
                    m_phase = DRAIN;
                    m_valid = m_valid && !acc;
                end else if (sent_n == LINES) begin
                    m_phase = DRAIN;
                    m_valid = 1'b0;
                end else if (!(m_valid && !acc)) begin
                    m_valid = (out_n < MAX_OUT);
                    m_line  = sent_n;
                end
            end
            DRAIN: begin
                if (m_out == 0 && !m_valid) begin
                    if (!m_bad && !FRAME_START) m_fcnt++;
                    m_phase = SENDER_GO ? ARMED : IDLE;
                end
                if (acc) m_valid = 1'b0;
                if (FRAME_START) m_bad = 1'b1;
            end
            default: m_phase = IDLE;
        endcase
        m_sent = sent_n;
        m_out  = out_n;
        if (urun_set) m_urun = 1'b1;
        else if (UNDERRUN_CLR) m_urun = 1'b0;

        @(negedge ACLK);
        LINE_DONE    = 1'b0;
        FRAME_START  = 1'b0;
        UNDERRUN_CLR = 1'b0;
        done_pulse   = 1'b0;
        cyc++;
    endtask

    task automatic start_frame();
        c0 = cyc;
        acc_off.delete();
        acc_lines.delete();
        FRAME_START = 1'b1;
        step();
    endtask

    // Expected acceptance offsets for a 4-line frame, MAX_OUT=2, ready
    // always high and each done 3 cycles after its acceptance.
    task automatic check_basic_timing(string tag);
        int exp_off[4];
        exp_off = '{1, 2, 5, 6};
        check({tag, "_n"}, acc_off.size(), 4);
        for (int i = 0; i < 4 && i < acc_off.size(); i++) begin
            check({tag, "_off"}, acc_off[i], exp_off[i]);
            check({tag, "_line"}, acc_lines[i], i);
        end
    endtask

    task automatic async_reset();
        #2;
        ARESETN = 1'b0;
        #1;
        check("rst_valid", REQ_VALID, 0);
        check("rst_run", SENDER_RUN, 0);
        check("rst_urun", UNDERRUN, 0);
        check("rst_line", REQ_LINE, 0);
        model_reset();
        @(negedge ACLK);
        @(negedge ACLK);
        ARESETN = 1'b1;
    endtask

    initial begin
        int fc;
        model_reset();
        repeat (2) @(negedge ACLK);
        check("reset_valid", REQ_VALID, 0);
        check("reset_run", SENDER_RUN, 0);
        check("reset_line", REQ_LINE, 0);
        check("reset_state", DBG_STATE, IDLE);
        ARESETN = 1'b1;

        // Basic frame.
        SENDER_GO = 1'b1;
        REQ_READY = 1'b1;
        step();
        check("armed", DBG_STATE, ARMED);
        step();
        start_frame();
        repeat (11) step();
        check_basic_timing("basic");
        check("basic_armed", DBG_STATE, ARMED);
`ifdef SENDER_FRAME_CNT_EN
        check("basic_fcnt", FRAME_CNT, 1);
`endif

        // Backpressure on the first request.
        REQ_READY = 1'b0;
        start_frame();
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", REQ_VALID, 1);
            check("bp_line", REQ_LINE, 0);
            step();
        end
        REQ_READY = 1'b1;
        step();
        check("bp_acc_n", acc_off.size(), 1);
        if (acc_off.size() > 0) check("bp_acc_off", acc_off[0], 6);
        repeat (20) step();

        // GO drops while line 1 is being requested.
        start_frame();
        step();
        SENDER_GO = 1'b0;
        repeat (15) step();
        check("stop_n", acc_off.size(), LINES);
        check("stop_idle", DBG_STATE, IDLE);
        check("stop_run", SENDER_RUN, 0);
        FRAME_START = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            check("stop_noreq", REQ_VALID, 0);
            step();
        end

        // Underrun: last LINE_DONE withheld, second FRAME_START in DRAIN.
        SENDER_GO = 1'b1;
        step();
        step();
        start_frame();
        repeat (8) step();
        hold_done = 1'b1;
        repeat (3) step();
        check("ur_drain", DBG_STATE, DRAIN);
        fc = m_fcnt;
        FRAME_START  = 1'b1;
        UNDERRUN_CLR = 1'b1;
        step();
        check("ur_set", UNDERRUN, 1);
        repeat (2) step();
        check("ur_still_drain", DBG_STATE, DRAIN);
        hold_done = 1'b0;
        step();
        step();
        check("ur_armed", DBG_STATE, ARMED);
`ifdef SENDER_FRAME_CNT_EN
        check("ur_fcnt", FRAME_CNT, fc);
`endif
        start_frame();
        check("ur_restart_valid", REQ_VALID, 1);
        check("ur_restart_line", REQ_LINE, 0);
        repeat (15) step();
        check("ur_sticky", UNDERRUN, 1);
        UNDERRUN_CLR = 1'b1;
        step();
        check("ur_clr", UNDERRUN, 0);

        // Stray LINE_DONE pulses while idle must not disturb the credits.
        SENDER_GO = 1'b0;
        repeat (2) step();
        for (int i = 0; i < 3; i++) begin
            done_pulse = 1'b1;
            step();
        end
        SENDER_GO = 1'b1;
        step();
        start_frame();
        repeat (11) step();
        check_basic_timing("stray");

        // Asynchronous reset in the middle of FETCH.
        start_frame();
        repeat (2) step();
        async_reset();
        step();
        check("rr_armed", DBG_STATE, ARMED);
        for (int i = 0; i < 3; i++) begin
            check("rr_noreq", REQ_VALID, 0);
            step();
        end

        // Randomized traffic.
        rand_lat = 6;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) SENDER_GO = !SENDER_GO;
            FRAME_START  = ($urandom_range(0, 24) == 0);
            REQ_READY    = ($urandom_range(0, 3) != 0);
            UNDERRUN_CLR = ($urandom_range(0, 29) == 0);
            done_pulse   = (m_out == 0) && ($urandom_range(0, 19) == 0);
            step();
        end
        compare_outputs();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sender_frame_seq.md
Name: sender_frame_seq

Overview:
- Sequences one HDMI sender frame at a time. Driven by the SENDER_GO level from the AXI-lite control registers; reports SENDER_RUN back to them.
- On each frame start it issues per-line fetch requests to the pixel line fetcher. Outstanding lines are bounded by a credit limit.
- Detects frame-buffer underrun: a new frame starts before the previous frame's lines are complete.

Parameters:
- LINES, 480, visible lines per frame; requests use line indices 0..LINES-1.
- LINE_W, 10, width of REQ_LINE; LINES <= 2**LINE_W.
- MAX_OUT, 2, maximum lines requested but not yet reported done (1..7).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; asynchronous, active-low
- SENDER_GO  in  1  run enable level from the control register
- SENDER_RUN  out  1  1 whenever state != IDLE
- FRAME_START  in  1  1-cycle pulse at the start of vertical blanking, from the video timing block
- REQ_VALID  out  1  line request valid
- REQ_READY  in  1  fetcher accepts the request
- REQ_LINE  out  LINE_W  line index of the request
- LINE_DONE  in  1  1-cycle pulse; one requested line has been fully fetched
- UNDERRUN  out  1  sticky underrun flag
- UNDERRUN_CLR  in  1  1-cycle clear pulse for UNDERRUN
- FRAME_CNT  out  16  completed-frame count (only with FRAME_CNT_EN)

Behaviour:
- Reset (async assert, sync release) drives state=IDLE, REQ_VALID=0, REQ_LINE=0, outstanding=0, UNDERRUN=0, FRAME_CNT=0, SENDER_RUN=0.
- All outputs are registered.

States:
- IDLE: if SENDER_GO=1, go to ARMED next cycle. FRAME_START is ignored.
- ARMED:
  - If SENDER_GO=0, go to IDLE.
  - Else on FRAME_START go to FETCH with next_line=0, and REQ_VALID=1, REQ_LINE=0 in the same edge. Latency is FRAME_START in cycle t -> REQ_VALID high in cycle t+1.
- FETCH:
  - A request completes on REQ_VALID & REQ_READY. On completion, outstanding+1 and next_line+1.
  - REQ_VALID is reasserted with the next index only while next_line < LINES and outstanding (registered value after this cycle's update) < MAX_OUT.
  - Once REQ_VALID is high, it and REQ_LINE stay stable until accepted.
  - After line LINES-1 is accepted, go to DRAIN.
  - SENDER_GO=0 in FETCH does not abort; the frame finishes.
- DRAIN:
  - Exit when outstanding=0 and REQ_VALID=0: to ARMED if SENDER_GO=1, else to IDLE.

Outstanding counter:
- REQ handshake and LINE_DONE in the same cycle leave the count unchanged.
- LINE_DONE with outstanding=0 is ignored; the count never underflows.

Underrun:
- FRAME_START in FETCH or DRAIN sets UNDERRUN.
- FETCH aborts to DRAIN: no further requests, but a REQ_VALID already high is held until accepted.
- The frame that triggered underrun is not served; the next FRAME_START after returning to ARMED is.
- Set wins over a simultaneous UNDERRUN_CLR.

Optional Feature:
- Macro: SENDER_FRAME_CNT_EN.
- Defined: FRAME_CNT port present. It increments by 1 on each DRAIN exit of a frame that had no underrun, and wraps 0xFFFF -> 0x0000.
- Undefined: FRAME_CNT port and counter absent; all other behaviour identical.

Decomposition:
- Package sender_pkg:
  - state enum seq_state_t {IDLE, ARMED, FETCH, DRAIN}.
  - FRAME_CNT_W=16 constant.
- One natural sub-module, sender_credit_cnt: outstanding counter with inc, dec and saturation guard.
  - Ports: ACLK, ARESETN, inc, dec, count, below_max.

Test Plan:
- Basic frame (LINES=4, MAX_OUT=2, REQ_READY=1, each LINE_DONE 3 cycles after its acceptance):
  - GO=1, then FRAME_START -> REQ_LINE 0,1 issued, then 2,3 each paced by LINE_DONE.
  - SENDER_RUN=1 throughout; returns to ARMED after the 4th LINE_DONE; FRAME_CNT=1.
- Backpressure: REQ_READY=0 for 5 cycles while REQ_VALID=1 -> REQ_VALID and REQ_LINE=0 held stable, then accepted on the first REQ_READY=1.
- Stop: GO drops during FETCH at line 1 -> lines 2,3 still issued; IDLE after drain; SENDER_RUN=0; a subsequent FRAME_START produces no request.
- Underrun (one LINE_DONE withheld):
  - Second FRAME_START in DRAIN -> UNDERRUN=1, FRAME_CNT unchanged.
  - After the late LINE_DONE, state goes to ARMED and the next FRAME_START starts line 0.
  - UNDERRUN_CLR in the same cycle as the set pulse leaves UNDERRUN=1.
- Simultaneous inc/dec: REQ handshake and LINE_DONE in the same cycle -> outstanding unchanged. Stray LINE_DONE in IDLE -> outstanding stays 0.
- Reset mid-FETCH: ARESETN low asynchronously -> REQ_VALID=0, SENDER_RUN=0 within the same cycle. After release with GO=1 -> ARMED, waits for FRAME_START.
